// File: rtl/road_sensor_conditioner.sv
// Roadside sensor front-end: siren debounce, per-road occupancy counting with
// jam hysteresis, and one-hot arbitration of the Emergency/Jam/Empty requests.
module road_sensor_conditioner #(
  parameter int CNT_W    = 6,
  parameter int JAM_TH   = 20,
  parameter int JAM_HYST = 4,
  parameter int DEB_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] siren,
  input  logic [3:0] veh_in,
  input  logic [3:0] veh_out,
  output logic [3:0] Emergency,
  output logic [3:0] Jam,
  output logic [3:0] Empty
);

  localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W:0]   JAM_SET  = (CNT_W+1)'(JAM_TH);
  localparam logic [CNT_W:0]   JAM_CLR  = (CNT_W+1)'(JAM_TH - JAM_HYST);

  logic [CNT_W-1:0] count_r [4];
  logic [CNT_W-1:0] count_s [4];
  logic [DW-1:0]    run_r   [4];
  logic [DW-1:0]    run_s   [4];
  logic [3:0]       deb_r, deb_s;
  logic [3:0]       jam_r, jam_s;
  logic [3:0]       empty_s;

  // Fixed priority east > north > west > south.
  function automatic logic [3:0] prio(input logic [3:0] req);
    logic [3:0] g;
    if (req[3])      g = 4'b1000;
    else if (req[2]) g = 4'b0100;
    else if (req[1]) g = 4'b0010;
    else if (req[0]) g = 4'b0001;
    else             g = 4'b0000;
    return g;
  endfunction

  // Keep the current one-hot grant while its road still requests, else re-select.
  function automatic logic [3:0] arb(input logic [3:0] grant, input logic [3:0] req);
    logic [3:0] g;
    if ((grant & req) != 4'b0000) g = grant;
    else                          g = prio(req);
    return g;
  endfunction

  // Per-road next-state: occupancy, siren debounce, jam flag and empty status.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      count_s[i] = count_r[i];
      run_s[i]   = run_r[i];
      deb_s[i]   = deb_r[i];
      jam_s[i]   = jam_r[i];
      empty_s[i] = 1'b0;

      if (veh_in[i] && !veh_out[i]) begin
        if (count_r[i] != CNT_MAX) count_s[i] = count_r[i] + 1'b1;
        else                       count_s[i] = count_r[i];
      end else if (veh_out[i] && !veh_in[i]) begin
        if (count_r[i] != CNT_ZERO) count_s[i] = count_r[i] - 1'b1;
        else                        count_s[i] = count_r[i];
      end else begin
        count_s[i] = count_r[i];
      end

      if (siren[i] != deb_r[i]) begin
        if (run_r[i] == DEB_LAST) begin
          deb_s[i] = ~deb_r[i];
          run_s[i] = {DW{1'b0}};
        end else begin
          deb_s[i] = deb_r[i];
          run_s[i] = run_r[i] + 1'b1;
        end
      end else begin
        deb_s[i] = deb_r[i];
        run_s[i] = {DW{1'b0}};
      end

      // Jam and empty look at the already-updated count, one edge after the pulse.
      if ({1'b0, count_r[i]} >= JAM_SET)     jam_s[i] = 1'b1;
      else if ({1'b0, count_r[i]} < JAM_CLR) jam_s[i] = 1'b0;
      else                                   jam_s[i] = jam_r[i];

      if (count_r[i] == CNT_ZERO) empty_s[i] = 1'b1;
      else                        empty_s[i] = 1'b0;
    end
  end

  // State and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        count_r[i] <= CNT_ZERO;
        run_r[i]   <= {DW{1'b0}};
      end
      deb_r     <= 4'b0000;
      jam_r     <= 4'b0000;
      Emergency <= 4'b0000;
      Jam       <= 4'b0000;
      Empty     <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        count_r[i] <= count_s[i];
        run_r[i]   <= run_s[i];
      end
      deb_r     <= deb_s;
      jam_r     <= jam_s;
      Emergency <= arb(Emergency, deb_r);
      Jam       <= arb(Jam, jam_s);
      Empty     <= prio(empty_s);
    end
  end

endmodule

// File: tb/tb_road_sensor_conditioner.sv
// Directed bench for road_sensor_conditioner; expected values are hand-derived.
module tb_road_sensor_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] siren;
  logic [3:0] veh_in;
  logic [3:0] veh_out;
  logic [3:0] Emergency;
  logic [3:0] Jam;
  logic [3:0] Empty;

  int vec_cnt = 0;
  int err_cnt = 0;

  road_sensor_conditioner #(
    .CNT_W(6), .JAM_TH(20), .JAM_HYST(4), .DEB_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .siren(siren), .veh_in(veh_in), .veh_out(veh_out),
    .Emergency(Emergency), .Jam(Jam), .Empty(Empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; siren = 4'b0000; veh_in = 4'b0000; veh_out = 4'b0000;
    tick(); tick();
    vec_cnt++;
    if ({Emergency, Jam, Empty} !== 12'h000) begin
      $display("FAIL reset_state: got E=%b J=%b M=%b, want all 0000", Emergency, Jam, Empty);
      err_cnt++;
    end
    rst = 1'b0;
    tick();
    vec_cnt++;
    if ({Emergency, Jam, Empty} !== {4'b0000, 4'b0000, 4'b1000}) begin
      $display("FAIL first_edge: got E=%b J=%b M=%b, want 0000 0000 1000", Emergency, Jam, Empty);
      err_cnt++;
    end
    #2 rst = 1'b1;
    #1;
    vec_cnt++;
    if (Empty !== 4'b0000) begin
      $display("FAIL async_reset_idle: Empty got %b want 0000", Empty);
      err_cnt++;
    end
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (Empty !== 4'b1000) begin
      $display("FAIL release_empty: Empty got %b want 1000", Empty);
      err_cnt++;
    end
  endtask

  task automatic test_debounce();
    siren = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (Emergency !== 4'b0000) begin
        $display("FAIL glitch_high[%0d]: Emergency got %b want 0000", i, Emergency);
        err_cnt++;
      end
    end
    siren = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec_cnt++;
      if (Emergency !== 4'b0000) begin
        $display("FAIL glitch_after[%0d]: Emergency got %b want 0000", i, Emergency);
        err_cnt++;
      end
    end
    siren = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vec_cnt++;
      if (Emergency !== ((i == 5) ? 4'b0100 : 4'b0000)) begin
        $display("FAIL deb_rise[%0d]: Emergency got %b want %b", i, Emergency,
                 (i == 5) ? 4'b0100 : 4'b0000);
        err_cnt++;
      end
    end
    siren = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vec_cnt++;
      if (Emergency !== ((i == 5) ? 4'b0000 : 4'b0100)) begin
        $display("FAIL deb_fall[%0d]: Emergency got %b want %b", i, Emergency,
                 (i == 5) ? 4'b0000 : 4'b0100);
        err_cnt++;
      end
    end
  endtask

  task automatic test_emergency_handover();
    siren = 4'b0100;
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++;
    if (Emergency !== 4'b0100) begin
      $display("FAIL north_grant: Emergency got %b want 0100", Emergency);
      err_cnt++;
    end
    siren = 4'b1100;
    for (int i = 0; i < 6; i++) begin
      tick();
      vec_cnt++;
      if (Emergency !== 4'b0100) begin
        $display("FAIL hold_north[%0d]: Emergency got %b want 0100", i, Emergency);
        err_cnt++;
      end
    end
    siren = 4'b1000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vec_cnt++;
      if (Emergency !== ((i == 5) ? 4'b1000 : 4'b0100)) begin
        $display("FAIL handover[%0d]: Emergency got %b want %b", i, Emergency,
                 (i == 5) ? 4'b1000 : 4'b0100);
        err_cnt++;
      end
    end
    siren = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++;
    if (Emergency !== 4'b0000) begin
      $display("FAIL east_release: Emergency got %b want 0000", Emergency);
      err_cnt++;
    end
  endtask

  task automatic test_jam_hysteresis();
    veh_in = 4'b0010;
    for (int i = 0; i < 20; i++) tick();
    vec_cnt++;
    if (Jam !== 4'b0000) begin
      $display("FAIL jam_at_20th_edge: Jam got %b want 0000", Jam);
      err_cnt++;
    end
    veh_in = 4'b0000;
    tick();
    vec_cnt++;
    if (Jam !== 4'b0010) begin
      $display("FAIL jam_set: Jam got %b want 0010", Jam);
      err_cnt++;
    end
    veh_out = 4'b0010;
    for (int i = 0; i < 4; i++) tick();
    veh_out = 4'b0000;
    tick();
    vec_cnt++;
    if (Jam !== 4'b0010) begin
      $display("FAIL jam_hold_16: Jam got %b want 0010", Jam);
      err_cnt++;
    end
    veh_out = 4'b0010;
    tick();
    veh_out = 4'b0000;
    vec_cnt++;
    if (Jam !== 4'b0010) begin
      $display("FAIL jam_lag_15: Jam got %b want 0010", Jam);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (Jam !== 4'b0000) begin
      $display("FAIL jam_clear_15: Jam got %b want 0000", Jam);
      err_cnt++;
    end
    veh_out = 4'b0010;
    for (int i = 0; i < 15; i++) tick();
    veh_out = 4'b0000;
    tick();
  endtask

  task automatic test_counter_edges();
    veh_in = 4'b1110;
    tick();
    veh_in = 4'b0001;
    tick();
    vec_cnt++;
    if (Empty !== 4'b0001) begin
      $display("FAIL empty_south_only: Empty got %b want 0001", Empty);
      err_cnt++;
    end
    for (int i = 1; i < 70; i++) tick();
    veh_in = 4'b0000;
    tick();
    vec_cnt++;
    if ({Jam, Empty} !== {4'b0001, 4'b0000}) begin
      $display("FAIL sat_jam: got J=%b M=%b want 0001 0000", Jam, Empty);
      err_cnt++;
    end
    veh_out = 4'b0001;
    for (int i = 0; i < 62; i++) tick();
    veh_out = 4'b0000;
    tick();
    vec_cnt++;
    if ({Jam, Empty} !== {4'b0000, 4'b0000}) begin
      $display("FAIL sat_63_down_to_1: got J=%b M=%b want 0000 0000", Jam, Empty);
      err_cnt++;
    end
    veh_in = 4'b0001; veh_out = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    veh_in = 4'b0000; veh_out = 4'b0000;
    tick();
    vec_cnt++;
    if (Empty !== 4'b0000) begin
      $display("FAIL in_out_same: Empty got %b want 0000", Empty);
      err_cnt++;
    end
    veh_out = 4'b0001;
    tick();
    tick();
    tick();
    veh_out = 4'b0000;
    tick();
    vec_cnt++;
    if (Empty !== 4'b0001) begin
      $display("FAIL underflow_hold: Empty got %b want 0001", Empty);
      err_cnt++;
    end
  endtask

  task automatic test_empty_priority();
    veh_in = 4'b1001;
    tick(); tick();
    veh_in = 4'b0001;
    tick(); tick(); tick();
    veh_in = 4'b0000; veh_out = 4'b0110;
    tick();
    veh_out = 4'b0000;
    tick();
    vec_cnt++;
    if (Empty !== 4'b0100) begin
      $display("FAIL empty_north: Empty got %b want 0100", Empty);
      err_cnt++;
    end
    veh_in = 4'b0100;
    tick();
    veh_in = 4'b0000;
    vec_cnt++;
    if (Empty !== 4'b0100) begin
      $display("FAIL empty_lag: Empty got %b want 0100", Empty);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (Empty !== 4'b0010) begin
      $display("FAIL empty_west: Empty got %b want 0010", Empty);
      err_cnt++;
    end
  endtask

  task automatic test_async_reset();
    siren = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++;
    if (Emergency !== 4'b0001) begin
      $display("FAIL south_emergency: Emergency got %b want 0001", Emergency);
      err_cnt++;
    end
    #3 rst = 1'b1;
    #1;
    vec_cnt++;
    if ({Emergency, Jam, Empty} !== 12'h000) begin
      $display("FAIL async_reset_busy: got E=%b J=%b M=%b want all 0000", Emergency, Jam, Empty);
      err_cnt++;
    end
    #1 rst = 1'b0;
    tick();
    vec_cnt++;
    if ({Emergency, Empty} !== {4'b0000, 4'b1000}) begin
      $display("FAIL post_reset: got E=%b M=%b want 0000 1000", Emergency, Empty);
      err_cnt++;
    end
    siren = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_emergency_handover();
    test_jam_hysteresis();
    test_counter_edges();
    test_empty_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/road_sensor_conditioner.md
# road_sensor_conditioner

Front-end stage that turns raw per-road roadside sensor signals into the `Emergency`, `Jam` and `Empty` request vectors consumed by the traffic light controller. It debounces siren detectors and keeps a saturating vehicle-occupancy count per road. It arbitrates each request class down to at most one asserted bit, so the controller always sees either 4'b0000 or a clean one-hot code. Outputs are registered and wire directly to the controller's request inputs.

## Interface

Bit order everywhere: bit3 = east, bit2 = north, bit1 = west, bit0 = south.

Parameters:
- `CNT_W`, 6: occupancy counter width per road.
- `JAM_TH`, 20: occupancy at or above which a road becomes jammed.
- `JAM_HYST`, 4: a jammed road clears when occupancy falls below `JAM_TH - JAM_HYST`. Legal range: `0 ≤ JAM_HYST < JAM_TH`.
- `DEB_LEN`, 4: consecutive identical siren samples required to change the debounced state. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `siren`, input, 4: raw siren detector level per road, synchronous to `clk`.
- `veh_in`, input, 4: one-cycle pulse per vehicle entering a road's queue.
- `veh_out`, input, 4: one-cycle pulse per vehicle leaving a road's queue.
- `Emergency`, output, 4: registered; 0000 or one-hot.
- `Jam`, output, 4: registered; 0000 or one-hot.
- `Empty`, output, 4: registered; 0000 or one-hot.

## Operation

- **Reset.** While `rst` is high:
  - counters = 0;
  - debounce run-counters = 0;
  - debounced sirens = 0;
  - jam flags = 0;
  - grants = 0;
  - `Emergency` = `Jam` = `Empty` = 4'b0000.
- **Siren debounce** (per road). A run-counter counts consecutive samples that differ from the current debounced value. It resets to 0 on any sample that equals the debounced value. When it reaches `DEB_LEN`, the debounced value toggles and the run-counter returns to 0.
- **Occupancy counter** (per road):
  - `veh_in` only: +1, saturating at 2^`CNT_W`−1.
  - `veh_out` only: −1, saturating at 0.
  - Both, or neither: unchanged.
- **Jam flag** (per road):
  - Set when count ≥ `JAM_TH`.
  - Cleared when count < `JAM_TH − JAM_HYST`.
  - Otherwise holds.
- **Emergency arbiter** (state: registered one-hot grant):
  - HOLD: the grant is nonzero and that road's debounced siren is still 1. Output is unchanged, and there is no pre-emption by higher-priority roads.
  - SELECT: otherwise, grant the highest-priority debounced siren (E > N > W > S), or 0000 if none.
- **Jam arbiter:** identical HOLD/SELECT scheme, using the jam flags.
- **Empty selector:** no hold. The output is the highest-priority road with count == 0, or 0000 if every road has occupancy.
- The three classes are independent. Overriding Jam/Empty while an emergency is active is the controller's job, not this block's.

## Timing

- A `veh_in`/`veh_out` pulse sampled at edge k updates the counter at edge k. `Jam` and `Empty` reflect the new count at edge k+1.
- Siren: if the first high sample is at edge k and every sample through edge k+DEB_LEN−1 is high, the debounced siren rises at edge k+DEB_LEN−1. `Emergency` rises at edge k+DEB_LEN. Release has the same latency.
- Glitch filtering: a siren pulse shorter than `DEB_LEN` cycles never reaches `Emergency`.
- Arbiter handover: when the held road drops, a waiting lower-priority road is granted on the same edge the held road's output clears. No idle 0000 cycle appears if another request is pending.
- Asynchronous `rst` mid-operation clears all state immediately.
- The first edge after reset release gives `Empty` = 4'b1000, since all roads are empty and east has priority.

## Test plan

- **Reset/idle.** Assert `rst` async mid-cycle → all outputs 0000 immediately. Release with no activity → `Empty`=1000 after 1 edge; `Jam`=`Emergency`=0000.
- **Debounce.** `DEB_LEN`=4, siren=0100 for 3 cycles then 0 → `Emergency` stays 0000. Siren=0100 held → `Emergency`=0100 exactly 4 edges after the first high sample. Drop it → 0000 4 edges later.
- **Emergency hold and handover.** North siren debounced and granted, then east siren also debounced → `Emergency` stays 0100. North released → `Emergency`=1000 on the same edge, with no 0000 gap.
- **Jam hysteresis.** 20 `veh_in` pulses on west → `Jam`=0010 one edge after the 20th. `veh_out` down to count 16 → still 0010. Count 15 → 0000.
- **Counter edges.** 70 `veh_in` pulses on south with `CNT_W`=6 → count saturates at 63. Simultaneous `veh_in`+`veh_out` → count unchanged. `veh_out` at 0 → stays 0, and `Empty` includes south.
- **Empty priority.** Counts E=3, N=0, W=0, S=5 → `Empty`=0100. Then a north `veh_in` → `Empty`=0010 one edge after the counter update.
